// File: rtl/sd_pkg.sv
// Shared definitions for the SD block-read arbiter: FSM encoding, block-size constants
// and the saturating byte-count helper.
package sd_pkg;

    localparam int unsigned SD_BLOCK_SIZE       = 512;
    localparam int unsigned BLOCK_BYTES_DEFAULT = SD_BLOCK_SIZE;
    localparam int unsigned BYTE_CNT_W          = 10;
    localparam int unsigned BYTE_CNT_MAX        = (1 << BYTE_CNT_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } sd_state_e;

    // Byte counter sticks at its maximum instead of wrapping.
    function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
        return (v == BYTE_CNT_W'(BYTE_CNT_MAX)) ? v : v + BYTE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the pointer breaks ties, and a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = pointer ? 2'b10 : 2'b01;
            default: grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares one SD controller between two block-read requesters: round-robin grant,
// command issue, byte forwarding, and done/err reporting per transaction.
module sd_block_arbiter
    import sd_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    output logic [1:0]  gnt,
    output logic [1:0]  rd_valid,
    output logic [7:0]  rd_data,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        SDctrl_start,
    output logic [31:0] SDctrl_address,
    input  logic        SDctrl_available,
    input  logic        SDctrl_valid,
    input  logic [7:0]  SDctrl_data
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sd_state_e              state, state_d;
    logic [1:0]             gnt_d, rd_valid_d, done_d, err_d;
    logic [1:0]             arb_grant_c;
    logic [7:0]             rd_data_d;
    logic                   start_d;
    logic [31:0]            addr_d;
    logic [BYTE_CNT_W-1:0]  byte_cnt, byte_cnt_d, byte_cnt_n;
    logic [TMO_W-1:0]       tmo_cnt, tmo_cnt_d;
    logic                   ptr, ptr_d;
    logic                   cnt_err;

    rr_arb2 u_rr_arb2 (
        .req     (req),
        .pointer (ptr),
        .grant_c (arb_grant_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            gnt            <= 2'b00;
            rd_valid       <= 2'b00;
            rd_data        <= 8'h00;
            done           <= 2'b00;
            err            <= 2'b00;
            SDctrl_start   <= 1'b0;
            SDctrl_address <= 32'h0;
            byte_cnt       <= '0;
            tmo_cnt        <= '0;
            ptr            <= 1'b0;
        end else begin
            state          <= state_d;
            gnt            <= gnt_d;
            rd_valid       <= rd_valid_d;
            rd_data        <= rd_data_d;
            done           <= done_d;
            err            <= err_d;
            SDctrl_start   <= start_d;
            SDctrl_address <= addr_d;
            byte_cnt       <= byte_cnt_d;
            tmo_cnt        <= tmo_cnt_d;
            ptr            <= ptr_d;
        end
    end

    // Next-state and next-output logic; done/err are launched on entry to DONE so they
    // line up with the DONE cycle while gnt is still asserted.
    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        rd_valid_d = 2'b00;
        rd_data_d  = rd_data;
        done_d     = 2'b00;
        err_d      = 2'b00;
        start_d    = SDctrl_start;
        addr_d     = SDctrl_address;
        byte_cnt_d = byte_cnt;
        byte_cnt_n = byte_cnt;
        tmo_cnt_d  = tmo_cnt;
        ptr_d      = ptr;
        cnt_err    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (SDctrl_available && (req != 2'b00)) begin
                    gnt_d      = arb_grant_c;
                    addr_d     = arb_grant_c[1] ? req_addr1 : req_addr0;
                    start_d    = 1'b1;
                    byte_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (!SDctrl_available) begin
                    start_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    start_d = 1'b0;
                    done_d  = gnt;
                    err_d   = gnt;
                    state_d = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt + TMO_W'(1);
                end
            end

            ST_BUSY: begin
                if (SDctrl_valid) begin
                    rd_valid_d = gnt;
                    rd_data_d  = SDctrl_data;
                    byte_cnt_n = sat_inc(byte_cnt);
                end
                byte_cnt_d = byte_cnt_n;
                // A byte arriving with the rising available edge is already in byte_cnt_n.
                if (SDctrl_available) begin
                    cnt_err = (byte_cnt_n != BYTE_CNT_W'(BLOCK_BYTES));
                    done_d  = gnt;
                    err_d   = gnt & {2{cnt_err}};
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                gnt_d   = 2'b00;
                ptr_d   = gnt[0];
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed self-checking bench for sd_block_arbiter with a scripted SD controller.
module tb_sd_block_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] req_addr0, req_addr1;
    logic [1:0]  gnt, rd_valid, done, err;
    logic [7:0]  rd_data;
    logic        SDctrl_start;
    logic [31:0] SDctrl_address;
    logic        SDctrl_available, SDctrl_valid;
    logic [7:0]  SDctrl_data;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] ADDR0 = 32'h0000_0400;
    localparam logic [31:0] ADDR1 = 32'h0001_2200;

    always #5 clk = ~clk;

    sd_block_arbiter #(.TIMEOUT(1024), .BLOCK_BYTES(512)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .req_addr0        (req_addr0),
        .req_addr1        (req_addr1),
        .gnt              (gnt),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .done             (done),
        .err              (err),
        .SDctrl_start     (SDctrl_start),
        .SDctrl_address   (SDctrl_address),
        .SDctrl_available (SDctrl_available),
        .SDctrl_valid     (SDctrl_valid),
        .SDctrl_data      (SDctrl_data)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00;
        SDctrl_available = 1'b0;
        SDctrl_valid = 1'b0;
        SDctrl_data = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One full block read; caller has set req. Ends one cycle after the done pulse.
    task automatic run_txn(input string name, input logic [1:0] exp_gnt, input logic [31:0] exp_addr,
                           input int nbytes, input bit avail_on_last, input bit exp_err,
                           input int issue_extra, input bit drop_req);
        int bad;
        logic [1:0] exp_err_v;
        bad = 0;
        exp_err_v = exp_err ? exp_gnt : 2'b00;
        SDctrl_available = 1'b1;
        step();
        n_cmp++; if (gnt !== exp_gnt) begin n_bad++; $display("FAIL %s gnt: got %b want %b", name, gnt, exp_gnt); end
        n_cmp++; if (SDctrl_start !== 1'b1) begin n_bad++; $display("FAIL %s start_rise: got %b want 1", name, SDctrl_start); end
        n_cmp++; if (SDctrl_address !== exp_addr) begin n_bad++; $display("FAIL %s address: got %h want %h", name, SDctrl_address, exp_addr); end
        if (drop_req) req = 2'b00;
        for (int k = 0; k < issue_extra; k++) begin
            SDctrl_valid = 1'b1;
            SDctrl_data = 8'hAA;
            step();
            if (rd_valid !== 2'b00 || SDctrl_start !== 1'b1) bad++;
        end
        SDctrl_valid = (issue_extra > 0);
        SDctrl_available = 1'b0;
        step();
        n_cmp++; if (SDctrl_start !== 1'b0) begin n_bad++; $display("FAIL %s start_fall: got %b want 0", name, SDctrl_start); end
        if (rd_valid !== 2'b00) bad++;
        for (int i = 0; i < nbytes; i++) begin
            SDctrl_valid = 1'b1;
            SDctrl_data = 8'(i);
            if (avail_on_last && i == nbytes - 1) SDctrl_available = 1'b1;
            step();
            if (rd_valid !== exp_gnt || rd_data !== 8'(i)) bad++;
            if (!(avail_on_last && i == nbytes - 1) && done !== 2'b00) bad++;
        end
        SDctrl_valid = 1'b0;
        if (!avail_on_last) begin
            SDctrl_available = 1'b1;
            step();
            if (rd_valid !== 2'b00) bad++;
        end
        n_cmp++; if (done !== exp_gnt) begin n_bad++; $display("FAIL %s done: got %b want %b", name, done, exp_gnt); end
        n_cmp++; if (err !== exp_err_v) begin n_bad++; $display("FAIL %s err: got %b want %b", name, err, exp_err_v); end
        n_cmp++; if (gnt !== exp_gnt) begin n_bad++; $display("FAIL %s gnt_at_done: got %b want %b", name, gnt, exp_gnt); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL %s byte_stream: got %0d bad cycles want 0", name, bad); end
        step();
        n_cmp++; if (done !== 2'b00 || err !== 2'b00) begin n_bad++; $display("FAIL %s done_pulse_len: got done=%b err=%b want 00", name, done, err); end
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL %s gnt_release: got %b want 00", name, gnt); end
    endtask

    task automatic test_reset();
        int bad;
        req_addr0 = ADDR0;
        req_addr1 = ADDR1;
        do_reset();
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset gnt: got %b want 00", gnt); end
        n_cmp++; if (rd_valid !== 2'b00) begin n_bad++; $display("FAIL reset rd_valid: got %b want 00", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset rd_data: got %h want 00", rd_data); end
        n_cmp++; if (done !== 2'b00 || err !== 2'b00) begin n_bad++; $display("FAIL reset done_err: got %b/%b want 00/00", done, err); end
        n_cmp++; if (SDctrl_start !== 1'b0) begin n_bad++; $display("FAIL reset start: got %b want 0", SDctrl_start); end
        n_cmp++; if (SDctrl_address !== 32'h0) begin n_bad++; $display("FAIL reset address: got %h want 0", SDctrl_address); end
        // Controller bytes with nobody granted must be dropped.
        bad = 0;
        SDctrl_available = 1'b1;
        for (int i = 0; i < 4; i++) begin
            SDctrl_valid = 1'b1;
            SDctrl_data = 8'h5A;
            step();
            if (rd_valid !== 2'b00 || gnt !== 2'b00) bad++;
        end
        SDctrl_valid = 1'b0;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL idle_valid_ignored: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_single();
        req = 2'b01;
        run_txn("single", 2'b01, ADDR0, 512, 1'b0, 1'b0, 0, 1'b0);
        req = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 2'b11;
        run_txn("rr0", 2'b01, ADDR0, 512, 1'b0, 1'b0, 0, 1'b0);
        run_txn("rr1", 2'b10, ADDR1, 512, 1'b0, 1'b0, 0, 1'b0);
        run_txn("rr2", 2'b01, ADDR0, 512, 1'b0, 1'b0, 0, 1'b0);
        run_txn("rr3", 2'b10, ADDR1, 512, 1'b0, 1'b0, 0, 1'b0);
        req = 2'b00;
        step();
    endtask

    task automatic test_short_block();
        do_reset();
        req = 2'b10;
        run_txn("short", 2'b10, ADDR1, 500, 1'b0, 1'b1, 0, 1'b1);
        step();
    endtask

    task automatic test_last_byte_with_available();
        req = 2'b01;
        run_txn("late_byte", 2'b01, ADDR0, 512, 1'b1, 1'b0, 2, 1'b0);
        req = 2'b00;
        step();
    endtask

    task automatic test_long_block();
        req = 2'b01;
        run_txn("long", 2'b01, ADDR0, 513, 1'b0, 1'b1, 0, 1'b0);
        req = 2'b00;
        step();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        req = 2'b01;
        SDctrl_available = 1'b1;
        step();
        n = 0;
        while (SDctrl_start === 1'b1 && n < 1100) begin
            n++;
            step();
        end
        n_cmp++; if (n !== 1024) begin n_bad++; $display("FAIL timeout start_cycles: got %0d want 1024", n); end
        n_cmp++; if (done !== 2'b01) begin n_bad++; $display("FAIL timeout done: got %b want 01", done); end
        n_cmp++; if (err !== 2'b01) begin n_bad++; $display("FAIL timeout err: got %b want 01", err); end
        req = 2'b00;
        step();
        n_cmp++; if (gnt !== 2'b00 || done !== 2'b00) begin n_bad++; $display("FAIL timeout release: got gnt=%b done=%b want 00/00", gnt, done); end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        req = 2'b01;
        SDctrl_available = 1'b1;
        step();
        SDctrl_available = 1'b0;
        step();
        for (int i = 0; i < 100; i++) begin
            SDctrl_valid = 1'b1;
            SDctrl_data = 8'(i);
            step();
        end
        n_cmp++; if (rd_valid !== 2'b01 || rd_data !== 8'h63) begin n_bad++; $display("FAIL midrst pre: got %b/%h want 01/63", rd_valid, rd_data); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== 2'b00 || rd_valid !== 2'b00) begin n_bad++; $display("FAIL midrst gnt_rdv: got %b/%b want 00/00", gnt, rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL midrst rd_data: got %h want 00", rd_data); end
        n_cmp++; if (SDctrl_start !== 1'b0 || SDctrl_address !== 32'h0) begin n_bad++; $display("FAIL midrst sdctrl: got %b/%h want 0/0", SDctrl_start, SDctrl_address); end
        SDctrl_valid = 1'b0;
        req = 2'b10;
        bad = 0;
        step();
        if (done !== 2'b00 || err !== 2'b00) bad++;
        step();
        if (done !== 2'b00 || err !== 2'b00) bad++;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done !== 2'b00 || gnt !== 2'b00 || SDctrl_start !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL midrst quiet: got %0d bad cycles want 0", bad); end
        run_txn("after_rst", 2'b10, ADDR1, 512, 1'b0, 1'b0, 0, 1'b0);
        req = 2'b00;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        req_addr0 = ADDR0;
        req_addr1 = ADDR1;
        SDctrl_available = 1'b0;
        SDctrl_valid = 1'b0;
        SDctrl_data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_short_block();
        test_last_byte_with_available();
        test_long_block();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
